// File: rtl/sw_debounce.sv
// Purpose : per-bit switch debouncer with 2-flop synchronizer and rise/fall pulse outputs.
// Latency : a clean level change is reflected on sw_out STABLE_CNT+2 clk edges after it reaches sw_in.
// Backpres: none; sw_in is sampled every cycle and the outputs are free-running levels/pulses.
//
// Ports:
//   clk     - single clock, all flops on its rising edge
//   rst     - asynchronous, active-high reset; clears every flop immediately
//   sw_in   - raw, asynchronous, bouncing switch pins (DW bits)
//   sw_out  - debounced switch state (DW bits)
//   sw_rise - one-cycle pulse per bit on a debounced 0->1 change
//   sw_fall - one-cycle pulse per bit on a debounced 1->0 change
module sw_debounce #(
  parameter int DW         = 4,
  parameter int STABLE_CNT = 250000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sw_in,
  output logic [DW-1:0] sw_out,
  output logic [DW-1:0] sw_rise,
  output logic [DW-1:0] sw_fall
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  // Count value on which the STABLE_CNT-th consecutive mismatching sample lands.
  localparam logic [CW-1:0] TERM = CW'(STABLE_CNT - 1);

  if (STABLE_CNT < 1) begin : g_bad_param
    $error("sw_debounce: STABLE_CNT must be >= 1");
  end

  // Two-stage synchronizer; nothing downstream ever looks at sw_in directly.
  logic [DW-1:0] sync1;
  logic [DW-1:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // One fully independent debounce slice per switch bit. A slice is "stable"
  // while its counter is 0 and "pending" while it is non-zero; the counter
  // saturates at TERM because reaching it always toggles and clears.
  for (genvar i = 0; i < DW; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          out_q;
    logic          rise_q;
    logic          fall_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt    <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sync2[i] == out_q) begin
          // Input agrees with the output: any partial count was a glitch.
          cnt <= '0;
        end else if (cnt == TERM) begin
          // Mismatch has persisted for STABLE_CNT samples: accept it.
          cnt    <= '0;
          out_q  <= ~out_q;
          rise_q <= ~out_q;
          fall_q <= out_q;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign sw_out[i]  = out_q;
    assign sw_rise[i] = rise_q;
    assign sw_fall[i] = fall_q;
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Purpose : directed bench for sw_debounce with a sample-window reference model.
// Latency : model and DUT are compared on every falling edge outside reset.
// Backpres: none; stimulus is applied on falling edges, outputs are sampled there too.
module tb_sw_debounce;

  localparam int DW = 4;
  localparam int N  = 4;

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          clk_en = 1'b0;
  logic [DW-1:0] sw_in  = '0;
  logic [DW-1:0] sw_out;
  logic [DW-1:0] sw_rise;
  logic [DW-1:0] sw_fall;

  int tests = 0;
  int fails = 0;
  int rise_cnt [DW];
  int fall_cnt [DW];

  sw_debounce #(.DW(DW), .STABLE_CNT(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_in   (sw_in),
    .sw_out  (sw_out),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  // Gateable clock so reset can be exercised with no edges at all.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Reference model: the value the debouncer acts on at any edge is the pin
  // value captured two edges earlier. The output bit flips when the last N
  // such samples all disagree with it.
  logic [DW-1:0] m_out  = '0;
  logic [DW-1:0] m_rise = '0;
  logic [DW-1:0] m_fall = '0;
  logic [DW-1:0] raw_q [$];
  logic [DW-1:0] vis_q [$];

  always @(posedge clk or posedge rst) begin
    logic [DW-1:0] flip;
    if (rst) begin
      raw_q.delete();
      vis_q.delete();
      repeat (2) raw_q.push_back('0);
      repeat (N) vis_q.push_back('0);
      m_out  = '0;
      m_rise = '0;
      m_fall = '0;
    end else begin
      raw_q.push_back(sw_in);
      vis_q.push_back(raw_q[0]);
      void'(raw_q.pop_front());
      void'(vis_q.pop_front());
      flip = '1;
      foreach (vis_q[j]) flip &= vis_q[j] ^ m_out;
      m_rise = flip & ~m_out;
      m_fall = flip & m_out;
      m_out  = m_out ^ flip;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle, tally pulses and compare against the model.
  task automatic tick();
    @(negedge clk);
    for (int b = 0; b < DW; b++) begin
      rise_cnt[b] += int'(sw_rise[b]);
      fall_cnt[b] += int'(sw_fall[b]);
    end
    if (!rst)
      check("model_cycle", int'({sw_out, sw_rise, sw_fall}), int'({m_out, m_rise, m_fall}));
  endtask

  function automatic int sum_rise();
    int s = 0;
    for (int b = 0; b < DW; b++) s += rise_cnt[b];
    return s;
  endfunction

  function automatic int sum_fall();
    int s = 0;
    for (int b = 0; b < DW; b++) s += fall_cnt[b];
    return s;
  endfunction

  initial begin
    int r0, f0, r2, f2, waited;
    for (int b = 0; b < DW; b++) begin
      rise_cnt[b] = 0;
      fall_cnt[b] = 0;
    end

    // Reset with the clock stopped.
    sw_in = 4'b0101;
    #1 rst = 1'b1;
    #1;
    check("reset_out",  int'(sw_out),  0);
    check("reset_rise", int'(sw_rise), 0);
    check("reset_fall", int'(sw_fall), 0);
    clk_en = 1'b1;
    repeat (3) tick();

    // Release with 0101 held: fresh rise on edge 6.
    rst = 1'b0;
    f0  = sum_fall();
    repeat (5) tick();
    check("rel_out_e5", int'(sw_out), 0);
    tick();
    check("rel_out_e6",  int'(sw_out),  int'(4'b0101));
    check("rel_rise_e6", int'(sw_rise), int'(4'b0101));
    check("rel_fall_e6", int'(sw_fall), 0);
    tick();
    check("rel_rise_e7",  int'(sw_rise), 0);
    check("rel_no_fall", sum_fall() - f0, 0);

    sw_in = '0;
    repeat (10) tick();
    check("clear_out", int'(sw_out), 0);

    // Bit 0 toggling every 2 cycles, then held high.
    r0 = rise_cnt[0];
    f0 = sum_fall();
    for (int i = 0; i < 10; i++) begin
      sw_in[0] = (i % 2 == 0);
      repeat (2) tick();
    end
    sw_in[0] = 1'b1;
    repeat (5) tick();
    check("tog_no_early", int'(sw_out[0]), 0);
    tick();
    check("tog_rise_e6", int'(sw_rise[0]), 1);
    repeat (3) tick();
    check("tog_rise_count", rise_cnt[0] - r0, 1);
    check("tog_fall_count", sum_fall() - f0, 0);

    sw_in = '0;
    repeat (10) tick();

    // Bit 2: 3-cycle glitch rejected, 4-cycle pulse accepted.
    r2 = rise_cnt[2];
    f2 = fall_cnt[2];
    sw_in[2] = 1'b1;
    repeat (3) tick();
    sw_in[2] = 1'b0;
    repeat (10) tick();
    check("glitch3_out",  int'(sw_out), 0);
    check("glitch3_rise", rise_cnt[2] - r2, 0);
    sw_in[2] = 1'b1;
    repeat (4) tick();
    sw_in[2] = 1'b0;
    repeat (2) tick();
    check("pulse4_out_hi", int'(sw_out),  int'(4'b0100));
    check("pulse4_rise",   int'(sw_rise), int'(4'b0100));
    repeat (4) tick();
    check("pulse4_out_lo", int'(sw_out),  0);
    check("pulse4_fall",   int'(sw_fall), int'(4'b0100));
    tick();
    check("pulse4_rise_count", rise_cnt[2] - r2, 1);
    check("pulse4_fall_count", fall_cnt[2] - f2, 1);

    // Simultaneous swap 0010 -> 1000 lands on one edge.
    sw_in = 4'b0010;
    repeat (8) tick();
    check("swap_pre_out", int'(sw_out), int'(4'b0010));
    sw_in  = 4'b1000;
    waited = 0;
    while (sw_out == 4'b0010 && waited < 20) begin
      tick();
      waited++;
    end
    check("swap_edges", waited, 6);
    check("swap_out",  int'(sw_out),  int'(4'b1000));
    check("swap_rise", int'(sw_rise), int'(4'b1000));
    check("swap_fall", int'(sw_fall), int'(4'b0010));

    // Asynchronous reset mid-count with the clock stopped.
    sw_in = 4'b1111;
    repeat (8) tick();
    check("arst_pre_out", int'(sw_out), int'(4'b1111));
    sw_in = '0;
    repeat (4) tick();
    check("arst_mid_out", int'(sw_out), int'(4'b1111));
    clk_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_out",  int'(sw_out),  0);
    check("arst_rise", int'(sw_rise), 0);
    check("arst_fall", int'(sw_fall), 0);
    #30;
    check("arst_hold_out",   int'(sw_out),  0);
    check("arst_hold_pulse", int'({sw_rise, sw_fall}), 0);
    rst = 1'b0;
    r0  = sum_rise();
    f0  = sum_fall();
    #2 clk_en = 1'b1;
    repeat (10) tick();
    check("post_rst_out",   int'(sw_out), 0);
    check("post_rst_rises", sum_rise() - r0, 0);
    check("post_rst_falls", sum_fall() - f0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
